// File: rtl/sent_tx_crc_engine.sv
// Symbol-serial CRC engine for the SENT transmitter. It folds one SYM_W-bit
// symbol per clock into the CRC, MSB first, and can optionally append one
// all-zero symbol to produce the SENT "recommended" CRC.
module sent_tx_crc_engine #(
    parameter int unsigned      CRC_W    = 4,
    parameter logic [CRC_W-1:0] POLY     = 4'b1101,
    parameter logic [CRC_W-1:0] SEED     = 4'b0101,
    parameter int unsigned      SYM_W    = 4,
    parameter int unsigned      MAX_SYMS = 8
) (
    input  logic             clk_tx,
    input  logic             reset_tx,
    input  logic             start_i,
    input  logic             aug_mode_i,
    input  logic             sym_valid_i,
    input  logic [SYM_W-1:0] sym_i,
    input  logic             sym_last_i,
    output logic             sym_ready_o,
    output logic             busy_o,
    output logic [CRC_W-1:0] crc_o,
    output logic             crc_valid_o,
    output logic             err_o
);

    localparam int unsigned      CNT_W    = $clog2(MAX_SYMS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_SYMS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_AUG
    } state_e;

    state_e             state_q,     state_d;
    logic [CRC_W-1:0]   lfsr_q,      lfsr_d;
    logic [CNT_W-1:0]   count_q,     count_d;
    logic               aug_q,       aug_d;
    logic               err_pend_q,  err_pend_d;
    logic [CRC_W-1:0]   crc_q,       crc_d;
    logic               crc_valid_q, crc_valid_d;
    logic               err_q,       err_d;

    logic [CRC_W-1:0]   sym_step;
    logic [CRC_W-1:0]   zero_step;
    logic               end_of_msg;

    // Full SYM_W-bit advance of the serial LFSR, unrolled into one clock.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc,
                                                  input logic [SYM_W-1:0] sym);
        logic [CRC_W-1:0] r;
        logic             fb;
        r = crc;
        for (int i = SYM_W - 1; i >= 0; i--) begin
            fb = r[CRC_W-1] ^ sym[i];
            r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        return r;
    endfunction

    assign sym_step   = crc_step(lfsr_q, sym_i);
    assign zero_step  = crc_step(lfsr_q, '0);
    assign end_of_msg = sym_last_i || (count_q == CNT_LAST);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path can infer a latch.
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        count_d     = count_q;
        aug_d       = aug_q;
        err_pend_d  = err_pend_q;
        crc_d       = crc_q;
        crc_valid_d = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    lfsr_d     = SEED;
                    count_d    = '0;
                    aug_d      = aug_mode_i;
                    err_pend_d = 1'b0;
                    state_d    = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (sym_valid_i) begin
                    lfsr_d  = sym_step;
                    count_d = count_q + CNT_W'(1);
                    if (end_of_msg) begin
                        // A message cut off by the symbol limit is flagged with its CRC.
                        if (aug_q) begin
                            err_pend_d = !sym_last_i;
                            state_d    = ST_AUG;
                        end else begin
                            crc_d       = sym_step;
                            crc_valid_d = 1'b1;
                            err_d       = !sym_last_i;
                            state_d     = ST_IDLE;
                        end
                    end
                end
            end
            ST_AUG: begin
                lfsr_d      = zero_step;
                crc_d       = zero_step;
                crc_valid_d = 1'b1;
                err_d       = err_pend_q;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_tx or posedge reset_tx) begin
        if (reset_tx) begin
            state_q     <= ST_IDLE;
            lfsr_q      <= SEED;
            count_q     <= '0;
            aug_q       <= 1'b0;
            err_pend_q  <= 1'b0;
            crc_q       <= '0;
            crc_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            count_q     <= count_d;
            aug_q       <= aug_d;
            err_pend_q  <= err_pend_d;
            crc_q       <= crc_d;
            crc_valid_q <= crc_valid_d;
            err_q       <= err_d;
        end
    end

    assign sym_ready_o = (state_q == ST_ACCUM);
    assign busy_o      = (state_q != ST_IDLE);
    assign crc_o       = crc_q;
    assign crc_valid_o = crc_valid_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_sent_tx_crc_engine.sv
// Directed bench for sent_tx_crc_engine: CRC4 default instance, a CRC6
// instance and a MAX_SYMS=1 instance, all driven by the same stimulus.
module tb_sent_tx_crc_engine;

    logic       clk_tx;
    logic       reset_tx;
    logic       start;
    logic       aug_mode;
    logic       sym_valid;
    logic [3:0] sym;
    logic       sym_last;

    logic       a_ready, a_busy, a_valid, a_err;
    logic [3:0] a_crc;
    logic       b_ready, b_busy, b_valid, b_err;
    logic [5:0] b_crc;
    logic       c_ready, c_busy, c_valid, c_err;
    logic [3:0] c_crc;

    int vectors;
    int miscompares;

    logic [3:0] msg [0:7];
    logic [3:0] exp_crc;

    sent_tx_crc_engine dut_a (
        .clk_tx(clk_tx), .reset_tx(reset_tx), .start_i(start), .aug_mode_i(aug_mode),
        .sym_valid_i(sym_valid), .sym_i(sym), .sym_last_i(sym_last),
        .sym_ready_o(a_ready), .busy_o(a_busy), .crc_o(a_crc),
        .crc_valid_o(a_valid), .err_o(a_err)
    );

    sent_tx_crc_engine #(.CRC_W(6), .POLY(6'b011001), .SEED(6'b010101)) dut_b (
        .clk_tx(clk_tx), .reset_tx(reset_tx), .start_i(start), .aug_mode_i(aug_mode),
        .sym_valid_i(sym_valid), .sym_i(sym), .sym_last_i(sym_last),
        .sym_ready_o(b_ready), .busy_o(b_busy), .crc_o(b_crc),
        .crc_valid_o(b_valid), .err_o(b_err)
    );

    sent_tx_crc_engine #(.MAX_SYMS(1)) dut_c (
        .clk_tx(clk_tx), .reset_tx(reset_tx), .start_i(start), .aug_mode_i(aug_mode),
        .sym_valid_i(sym_valid), .sym_i(sym), .sym_last_i(sym_last),
        .sym_ready_o(c_ready), .busy_o(c_busy), .crc_o(c_crc),
        .crc_valid_o(c_valid), .err_o(c_err)
    );

    initial clk_tx = 1'b0;
    always #5 clk_tx = ~clk_tx;

    // Bit-serial CRC4 over the concatenated message bit stream.
    function automatic logic [3:0] ref_crc4(input int n, input bit aug);
        logic [3:0] c;
        logic       fb;
        c = 4'b0101;
        for (int k = 0; k < (n + (aug ? 1 : 0)) * 4; k++) begin
            fb = c[3] ^ ((k / 4 < n) ? msg[k / 4][3 - (k % 4)] : 1'b0);
            c  = {c[2:0], 1'b0} ^ (fb ? 4'b1101 : 4'b0000);
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge clk_tx);
        #1;
    endtask

    task automatic begin_msg(input logic aug);
        start    = 1'b1;
        aug_mode = aug;
        tick();
        start    = 1'b0;
        aug_mode = 1'b0;
    endtask

    task automatic send_sym(input logic [3:0] s, input logic l);
        int budget;
        budget    = 0;
        sym_valid = 1'b1;
        sym       = s;
        sym_last  = l;
        while (a_ready !== 1'b1 && budget < 50) begin
            tick();
            budget++;
        end
        if (budget >= 50) begin
            vectors++; miscompares++;
            $display("FAIL handshake_timeout: ready=%b, wanted 1 within 50 cycles", a_ready);
        end else begin
            tick();
        end
        sym_valid = 1'b0;
        sym_last  = 1'b0;
    endtask

    task automatic send_msg(input int n, input int gap_max);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gap_max)) tick();
            send_sym(msg[i], i == n - 1);
        end
    endtask

    task automatic test_reset();
        reset_tx = 1'b1;
        #1;
        vectors++;
        if ({a_ready, a_busy, a_valid, a_err, a_crc} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_outputs: got rdy/busy/val/err/crc=%b, wanted 00000000",
                     {a_ready, a_busy, a_valid, a_err, a_crc});
        end
        tick(); tick();
        reset_tx = 1'b0;
        tick();
        vectors++;
        if (a_ready !== 1'b0 || a_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: ready=%b valid=%b, wanted 0 0", a_ready, a_valid);
        end
    endtask

    task automatic test_single_plain();
        begin_msg(1'b0);
        vectors++;
        if (a_ready !== 1'b1 || a_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL accum_ready: ready=%b busy=%b, wanted 1 1", a_ready, a_busy);
        end
        send_sym(4'h0, 1'b1);
        vectors++;
        if (a_valid !== 1'b1 || a_crc !== 4'h3 || a_err !== 1'b0) begin
            miscompares++;
            $display("FAIL crc4_zero: valid=%b crc=%h err=%b, wanted 1 3 0", a_valid, a_crc, a_err);
        end
        vectors++;
        if (c_valid !== 1'b1 || c_crc !== 4'h3 || c_err !== 1'b0) begin
            miscompares++;
            $display("FAIL max1_last: valid=%b crc=%h err=%b, wanted 1 3 0", c_valid, c_crc, c_err);
        end
        tick();
        vectors++;
        if (a_valid !== 1'b0 || a_crc !== 4'h3 || a_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL crc4_hold: valid=%b crc=%h busy=%b, wanted 0 3 0", a_valid, a_crc, a_busy);
        end
    endtask

    task automatic test_augmented();
        begin_msg(1'b1);
        send_sym(4'h0, 1'b1);
        vectors++;
        if (a_valid !== 1'b0 || a_ready !== 1'b0 || a_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL aug_cycle: valid=%b ready=%b busy=%b, wanted 0 0 1", a_valid, a_ready, a_busy);
        end
        tick();
        vectors++;
        if (a_valid !== 1'b1 || a_crc !== 4'hA || a_err !== 1'b0) begin
            miscompares++;
            $display("FAIL aug_crc: valid=%b crc=%h err=%b, wanted 1 a 0", a_valid, a_crc, a_err);
        end
        tick();
        vectors++;
        if (a_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL aug_pulse_width: valid=%b, wanted 0", a_valid);
        end
    endtask

    task automatic test_crc6();
        begin_msg(1'b0);
        send_sym(4'h0, 1'b1);
        vectors++;
        if (b_valid !== 1'b1 || b_crc !== 6'h34 || b_err !== 1'b0) begin
            miscompares++;
            $display("FAIL crc6_zero: valid=%b crc=%h err=%b, wanted 1 34 0", b_valid, b_crc, b_err);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        msg[0] = 4'hA; msg[1] = 4'h3; msg[2] = 4'hF;
        msg[3] = 4'h0; msg[4] = 4'h7; msg[5] = 4'hC;
        exp_crc = ref_crc4(6, 1'b0);
        begin_msg(1'b0);
        send_msg(6, 3);
        vectors++;
        if (a_valid !== 1'b1 || a_crc !== exp_crc) begin
            miscompares++;
            $display("FAIL b2b_msg1: valid=%b crc=%h, wanted 1 %h", a_valid, a_crc, exp_crc);
        end
        begin_msg(1'b0);
        vectors++;
        if (a_busy !== 1'b1 || a_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_start: busy=%b valid=%b, wanted 1 0", a_busy, a_valid);
        end
        msg[0] = 4'h5; msg[1] = 4'hE; msg[2] = 4'h1;
        msg[3] = 4'h9; msg[4] = 4'hB; msg[5] = 4'h2;
        exp_crc = ref_crc4(6, 1'b0);
        send_msg(6, 2);
        vectors++;
        if (a_valid !== 1'b1 || a_crc !== exp_crc) begin
            miscompares++;
            $display("FAIL b2b_msg2: valid=%b crc=%h, wanted 1 %h", a_valid, a_crc, exp_crc);
        end
        tick();
    endtask

    task automatic test_max_syms();
        for (int i = 0; i < 8; i++) msg[i] = 4'(i * 3 + 1);
        exp_crc = ref_crc4(8, 1'b0);
        begin_msg(1'b0);
        for (int i = 0; i < 8; i++) send_sym(msg[i], 1'b0);
        vectors++;
        if (a_valid !== 1'b1 || a_err !== 1'b1 || a_crc !== exp_crc) begin
            miscompares++;
            $display("FAIL max_term: valid=%b err=%b crc=%h, wanted 1 1 %h", a_valid, a_err, a_crc, exp_crc);
        end
        sym_valid = 1'b1;
        sym       = 4'h9;
        vectors++;
        if (a_ready !== 1'b0 || a_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ninth_sym_ready: ready=%b busy=%b, wanted 0 0", a_ready, a_busy);
        end
        tick();
        sym_valid = 1'b0;
        vectors++;
        if (a_valid !== 1'b0 || a_busy !== 1'b0 || a_crc !== exp_crc) begin
            miscompares++;
            $display("FAIL ninth_sym_ignored: valid=%b busy=%b crc=%h, wanted 0 0 %h",
                     a_valid, a_busy, a_crc, exp_crc);
        end
        // Augmented run cut off at the limit: error follows the delayed CRC.
        exp_crc = ref_crc4(8, 1'b1);
        begin_msg(1'b1);
        for (int i = 0; i < 8; i++) send_sym(msg[i], 1'b0);
        vectors++;
        if (a_valid !== 1'b0 || a_err !== 1'b0) begin
            miscompares++;
            $display("FAIL max_aug_early: valid=%b err=%b, wanted 0 0", a_valid, a_err);
        end
        tick();
        vectors++;
        if (a_valid !== 1'b1 || a_err !== 1'b1 || a_crc !== exp_crc) begin
            miscompares++;
            $display("FAIL max_aug_term: valid=%b err=%b crc=%h, wanted 1 1 %h", a_valid, a_err, a_crc, exp_crc);
        end
        tick();
        // Single-symbol limit without last: the MAX_SYMS=1 instance flags an error.
        begin_msg(1'b0);
        sym_valid = 1'b1;
        sym       = 4'h0;
        sym_last  = 1'b0;
        tick();
        sym_valid = 1'b0;
        vectors++;
        if (c_valid !== 1'b1 || c_err !== 1'b1 || c_crc !== 4'h3) begin
            miscompares++;
            $display("FAIL max1_nolast: valid=%b err=%b crc=%h, wanted 1 1 3", c_valid, c_err, c_crc);
        end
        send_sym(4'h0, 1'b1);
        tick();
    endtask

    task automatic test_robustness();
        int seen_valid;
        begin_msg(1'b0);
        send_sym(4'h4, 1'b0);
        send_sym(4'h8, 1'b0);
        send_sym(4'hD, 1'b0);
        sym_valid = 1'b1;
        sym       = 4'h6;
        sym_last  = 1'b1;
        reset_tx  = 1'b1;
        #1;
        vectors++;
        if ({a_ready, a_busy, a_valid, a_err, a_crc} !== 8'h00) begin
            miscompares++;
            $display("FAIL midmsg_reset: got rdy/busy/val/err/crc=%b, wanted 00000000",
                     {a_ready, a_busy, a_valid, a_err, a_crc});
        end
        seen_valid = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (a_valid === 1'b1) seen_valid++;
        end
        reset_tx  = 1'b0;
        sym_valid = 1'b0;
        sym_last  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (a_valid === 1'b1) seen_valid++;
        end
        vectors++;
        if (seen_valid !== 0) begin
            miscompares++;
            $display("FAIL reset_no_valid: crc_valid seen %0d times, wanted 0", seen_valid);
        end
        // Fresh message with a stray start in the middle; it must not reseed.
        msg[0] = 4'h7; msg[1] = 4'h2; msg[2] = 4'hB; msg[3] = 4'hE;
        exp_crc = ref_crc4(4, 1'b0);
        begin_msg(1'b0);
        send_sym(msg[0], 1'b0);
        send_sym(msg[1], 1'b0);
        begin_msg(1'b1);
        vectors++;
        if (a_busy !== 1'b1 || a_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL stray_start_state: busy=%b ready=%b, wanted 1 1", a_busy, a_ready);
        end
        send_sym(msg[2], 1'b0);
        send_sym(msg[3], 1'b1);
        vectors++;
        if (a_valid !== 1'b1 || a_crc !== exp_crc || a_err !== 1'b0) begin
            miscompares++;
            $display("FAIL no_reseed: valid=%b crc=%h err=%b, wanted 1 %h 0", a_valid, a_crc, a_err, exp_crc);
        end
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        start       = 1'b0;
        aug_mode    = 1'b0;
        sym_valid   = 1'b0;
        sym         = 4'h0;
        sym_last    = 1'b0;
        test_reset();
        test_single_plain();
        test_augmented();
        test_crc6();
        test_back_to_back();
        test_max_syms();
        test_robustness();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
